// File: rtl/codma_bus_responder_if.sv
// Bus handshake between the CODMA master and its system-memory responder.
// Burst requests, 64-bit read/write beats and completion strobes.
interface BUS_IF;
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  size;
    logic        grant;
    logic        read_valid;
    logic [63:0] read_data;
    logic        write_valid;
    logic [63:0] write_data;
    logic        write_done;

    modport master (
        output read, write, addr, size, write_valid, write_data,
        input  grant, read_valid, read_data, write_done
    );

    modport slave (
        input  read, write, addr, size, write_valid, write_data,
        output grant, read_valid, read_data, write_done
    );
endinterface

// File: rtl/codma_bus_responder.sv
// Memory-model responder for the CODMA bus: one-cycle grant, fixed-latency
// 64-bit read bursts, gap-tolerant write bursts, plus an idle-only backdoor.
module codma_bus_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned RD_LATENCY = 2,
    localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    BUS_IF.slave          bus_if,
    input  logic          bd_we_i,
    input  logic [AW-1:0] bd_addr_i,
    input  logic [31:0]   bd_wdata_i,
    output logic [31:0]   bd_rdata_o,
    output logic          busy_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT    = 3'd1,
        RD_WAIT  = 3'd2,
        RD_BURST = 3'd3,
        WR_BURST = 3'd4,
        WR_DONE  = 3'd5
    } state_e;

    localparam logic [3:0] WAIT_LAST = 4'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);

    // An odd final beat carries only its low word; the high half reads as zero.
    function automatic logic [63:0] pack_beat(input logic [31:0] lo,
                                              input logic [31:0] hi,
                                              input logic        has_hi);
        if (has_hi) begin
            pack_beat = {hi, lo};
        end else begin
            pack_beat = {32'h0000_0000, lo};
        end
    endfunction

    logic [31:0]   mem_r [MEM_WORDS];
    state_e        state_r, state_s;
    logic          is_rd_r;
    logic [AW-1:0] ptr_r;
    logic [4:0]    words_left_r;
    logic [3:0]    wait_cnt_r;
    logic          grant_r, read_valid_r, write_done_r, busy_r;
    logic [63:0]   read_data_r;

    logic          req_s, two_s, load_s, wr_beat_s, bd_wr_s;
    logic [AW-1:0] ptr_nx_s;
    logic [63:0]   beat_s;
    logic          unused_addr_s;

    assign req_s         = bus_if.read | bus_if.write;
    assign two_s         = (words_left_r >= 5'd2);
    assign ptr_nx_s      = ptr_r + AW'(1);
    assign beat_s        = pack_beat(mem_r[ptr_r], mem_r[ptr_nx_s], two_s);
    assign bd_wr_s       = bd_we_i & (state_r == IDLE);
    assign unused_addr_s = ^{bus_if.addr[31:AW+2], bus_if.addr[1:0]};

    assign bus_if.grant      = grant_r;
    assign bus_if.read_valid = read_valid_r;
    assign bus_if.read_data  = read_data_r;
    assign bus_if.write_done = write_done_r;
    assign busy_o            = busy_r;
    assign bd_rdata_o        = mem_r[bd_addr_i];

    // Next-state decode; load_s/wr_beat_s mark the edges that move a beat.
    always_comb begin
        state_s   = state_r;
        load_s    = 1'b0;
        wr_beat_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_s = GRANT;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (!is_rd_r) begin
                    state_s = WR_BURST;
                end else if (RD_LATENCY > 1) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_BURST;
                    load_s  = 1'b1;
                end
            end
            RD_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_s = RD_BURST;
                    load_s  = 1'b1;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            RD_BURST: begin
                if (words_left_r != 5'd0) begin
                    state_s = RD_BURST;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_BURST: begin
                if (bus_if.write_valid) begin
                    wr_beat_s = 1'b1;
                    if (words_left_r <= 5'd2) begin
                        state_s = WR_DONE;
                    end else begin
                        state_s = WR_BURST;
                    end
                end else begin
                    state_s = WR_BURST;
                end
            end
            WR_DONE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, registered outputs and burst bookkeeping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            is_rd_r      <= 1'b0;
            ptr_r        <= '0;
            words_left_r <= 5'd0;
            wait_cnt_r   <= 4'd0;
            grant_r      <= 1'b0;
            read_valid_r <= 1'b0;
            write_done_r <= 1'b0;
            busy_r       <= 1'b0;
            read_data_r  <= 64'h0;
        end else begin
            state_r      <= state_s;
            grant_r      <= (state_s == GRANT);
            read_valid_r <= load_s;
            write_done_r <= (state_s == WR_DONE);
            busy_r       <= (state_s != IDLE);
            if (load_s) begin
                read_data_r <= beat_s;
            end
            if (state_r == RD_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= 4'd0;
            end
            if ((state_r == IDLE) && req_s) begin
                is_rd_r      <= bus_if.read;
                ptr_r        <= bus_if.addr[AW+1:2];
                words_left_r <= (bus_if.size == 4'd0) ? 5'd1 : {1'b0, bus_if.size};
            end else if (load_s || wr_beat_s) begin
                ptr_r        <= ptr_r + AW'(2);
                words_left_r <= two_s ? (words_left_r - 5'd2) : 5'd0;
            end
        end
    end

    // Storage is deliberately left unreset; the backdoor only writes while idle.
    always_ff @(posedge clk_i) begin
        if (wr_beat_s) begin
            mem_r[ptr_r] <= bus_if.write_data[31:0];
        end else if (bd_wr_s) begin
            mem_r[bd_addr_i] <= bd_wdata_i;
        end
        if (wr_beat_s && two_s) begin
            mem_r[ptr_nx_s] <= bus_if.write_data[63:32];
        end
    end

endmodule

// File: tb/tb_codma_bus_responder.sv
// Directed bench for codma_bus_responder: read beats are predicted from a
// reference memory into a queue and popped as the responder returns them.
module tb_codma_bus_responder;
    localparam int MEM    = 1024;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = 10'd0;
    logic [31:0] bd_wdata = 32'd0;
    logic [31:0] bd_rdata;
    logic        busy;

    logic [31:0] model [MEM];
    logic [63:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    BUS_IF bus ();

    codma_bus_responder #(.MEM_WORDS(MEM), .RD_LATENCY(RD_LAT)) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .bus_if     (bus),
        .bd_we_i    (bd_we),
        .bd_addr_i  (bd_addr),
        .bd_wdata_i (bd_wdata),
        .bd_rdata_o (bd_rdata),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_read(input logic [31:0] a, input logic [3:0] sz);
        int          words;
        logic [9:0]  idx;
        logic [31:0] hi;
        words = (sz == 4'd0) ? 1 : int'(sz);
        idx   = a[11:2];
        while (words > 0) begin
            hi = (words >= 2) ? model[10'(idx + 10'd1)] : 32'd0;
            exp_q.push_back({hi, model[idx]});
            idx   = idx + 10'd2;
            words = words - 2;
        end
    endtask

    task automatic bd_check(input logic [9:0] a, input string tag);
        @(negedge clk);
        bd_addr = a;
        #1;
        check(tag, {32'd0, bd_rdata}, {32'd0, model[a]});
    endtask

    // hold=1 keeps read and write asserted throughout; stop_after>0 returns early.
    task automatic run_read(input logic [31:0] a, input logic [3:0] sz,
                            input logic hold, input int stop_after);
        int          got;
        logic [63:0] last;
        got  = 0;
        last = 64'd0;
        push_read(a, sz);
        @(negedge clk);
        bus.read  = 1'b1;
        bus.write = hold;
        bus.addr  = a;
        bus.size  = sz;
        @(negedge clk);
        check("grant", {63'd0, bus.grant}, 64'd1);
        check("busy_in_burst", {63'd0, busy}, 64'd1);
        if (!hold) begin
            bus.read = 1'b0;
        end
        for (int cyc = 1; cyc <= 40 && exp_q.size() > 0 && (stop_after == 0 || got < stop_after); cyc++) begin
            @(negedge clk);
            check("no_regrant", {63'd0, bus.grant}, 64'd0);
            if (got == 0 && bus.read_valid) check("rd_latency", 64'(cyc), 64'(RD_LAT));
            if (got > 0) check("rv_back2back", {63'd0, bus.read_valid}, 64'd1);
            if (bus.read_valid) begin
                last = exp_q.pop_front();
                check("rdata", bus.read_data, last);
                got++;
            end
        end
        if (stop_after == 0) begin
            check("beats_outstanding", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            @(negedge clk);
            bus.read  = 1'b0;
            bus.write = 1'b0;
            check("rv_drop", {63'd0, bus.read_valid}, 64'd0);
            check("rdata_hold", bus.read_data, last);
            check("idle_after_rd", {63'd0, busy}, 64'd0);
            check("no_grant_end", {63'd0, bus.grant}, 64'd0);
        end
    endtask

    initial begin
        bus.read = 1'b0; bus.write = 1'b0; bus.addr = 32'd0; bus.size = 4'd0;
        bus.write_valid = 1'b0; bus.write_data = 64'd0;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_grant", {63'd0, bus.grant}, 64'd0);
        check("rst_rv", {63'd0, bus.read_valid}, 64'd0);
        check("rst_rdata", bus.read_data, 64'd0);
        check("rst_wdone", {63'd0, bus.write_done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;

        // preload: word i = i + 0x90, so words 0x10..0x18 = 0xA0..0xA8
        for (int i = 0; i < MEM; i++) begin
            @(negedge clk);
            bd_we    = 1'b1;
            bd_addr  = 10'(i);
            bd_wdata = 32'(i) + 32'h90;
            model[i] = 32'(i) + 32'h90;
        end
        @(negedge clk);
        bd_we = 1'b0;
        bd_check(10'h10, "bd_w10");
        bd_check(10'h3FF, "bd_w3ff");

        run_read(32'h40, 4'd8, 1'b0, 0);
        run_read(32'h40, 4'd9, 1'b0, 0);

        // write burst with a gap; backdoor attempt during the gap must be ignored
        @(negedge clk);
        bus.write = 1'b1; bus.addr = 32'h100; bus.size = 4'd3;
        @(negedge clk);
        check("wr_grant", {63'd0, bus.grant}, 64'd1);
        bus.write = 1'b0;
        @(negedge clk);
        bus.write_valid = 1'b1; bus.write_data = 64'h00000002_00000001;
        @(negedge clk);
        bus.write_valid = 1'b0;
        bd_we = 1'b1; bd_addr = 10'h43; bd_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bd_we = 1'b0;
        bus.write_valid = 1'b1; bus.write_data = 64'h00000004_00000003;
        @(negedge clk);
        bus.write_valid = 1'b0;
        check("wdone_pulse", {63'd0, bus.write_done}, 64'd1);
        @(negedge clk);
        check("wdone_clear", {63'd0, bus.write_done}, 64'd0);
        check("idle_after_wr", {63'd0, busy}, 64'd0);
        model[10'h40] = 32'd1; model[10'h41] = 32'd2; model[10'h42] = 32'd3;
        for (int i = 0; i < 4; i++) bd_check(10'(10'h40 + i), "wr_word");

        // wrap-around from the top word
        run_read(32'hFFC, 4'd4, 1'b0, 0);

        // read and write together: read wins, held request is not re-granted
        run_read(32'h100, 4'd4, 1'b1, 0);
        for (int i = 0; i < 4; i++) bd_check(10'(10'h40 + i), "rw_nochange");

        // reset after beat 2 of 4
        run_read(32'h40, 4'd8, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", {63'd0, bus.grant}, 64'd0);
        check("mid_rst_rv", {63'd0, bus.read_valid}, 64'd0);
        check("mid_rst_rdata", bus.read_data, 64'd0);
        check("mid_rst_wdone", {63'd0, bus.write_done}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_read(32'h40, 4'd8, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/codma_bus_responder.md
Name: codma_bus_responder

Overview:
- Bus-side responder (memory model) for the BUS_IF protocol driven by the CODMA master.
- Accepts single read/write burst requests, issues a one-cycle grant, then:
  - returns read data as 64-bit beats with read_valid, or
  - absorbs 64-bit write beats into an internal 32-bit-word memory.
- Used as the system-memory endpoint in CODMA subsystem simulation; synthesisable, so it can also serve as an on-chip scratch RAM.

Parameters:
- MEM_WORDS, 1024: memory depth in 32-bit words; power of two.
- RD_LATENCY, 2: cycles from the grant cycle to the first read_valid beat; legal range 1..15.

Ports:
- clk_i  input  1  clock.
- reset_n_i  input  1  reset, asynchronous, active-low.
- bus_if  BUS_IF.slave  -  bus interface; members as seen by this block:
  - read  in  1  read request.
  - write  in  1  write request.
  - addr  in  32  byte address.
  - size  in  4  burst length in 32-bit words.
  - grant  out  1  request accepted.
  - read_valid  out  1  read beat valid.
  - read_data  out  64  read beat.
  - write_valid  in  1  write beat valid.
  - write_data  in  64  write beat.
  - write_done  out  1  write burst complete.
- bd_we_i  input  1  backdoor write enable.
- bd_addr_i  input  $clog2(MEM_WORDS)  backdoor word address.
- bd_wdata_i  input  32  backdoor write data.
- bd_rdata_o  output  32  backdoor read data, combinational from bd_addr_i.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: grant, read_valid, write_done, busy_o = 0; read_data = 0; FSM = IDLE; internal counters = 0.
  - Memory array is not reset.
  - Reset asserted mid-burst aborts the burst immediately. Words already written stay written; no further beats or done pulse.
- Addressing:
  - Word index = addr[$clog2(MEM_WORDS)+1:2]. addr[1:0] ignored. Upper addr bits ignored, i.e. modulo aliasing.
  - Word index increments per word and wraps from MEM_WORDS-1 to 0.
- Burst length:
  - words = size, except size 0 is treated as 1.
  - beats = ceil(words/2), so size 9 gives 5 beats.
- Beat packing:
  - [31:0] = word n, [63:32] = word n+1.
  - On an odd final beat, read_data[63:32] = 0 and write_data[63:32] is discarded.
- FSM states: IDLE, GRANT, RD_WAIT, RD_BURST, WR_BURST, WR_DONE.
- IDLE:
  - Samples read/write every cycle.
  - If either is high, latch addr and size, then go to GRANT.
  - read and write both high: read wins; write is ignored and must be re-requested.
- GRANT:
  - grant = 1 for exactly this one cycle.
  - Next state is RD_WAIT for reads and WR_BURST for writes.
  - Requests seen outside IDLE are ignored; a master holding read/write high is not double-granted.
- RD_WAIT:
  - Counts RD_LATENCY-1 cycles. With RD_LATENCY=1, goes straight to RD_BURST.
  - First read_valid occurs RD_LATENCY cycles after the grant cycle.
- RD_BURST:
  - read_valid = 1 on consecutive cycles, one beat per cycle, with no stalls.
  - After the last beat, return to IDLE; read_valid drops the next cycle.
  - read_data holds the last beat value while read_valid = 0.
- WR_BURST:
  - Each cycle with write_valid = 1 consumes one beat and writes one or two words.
  - Gaps where write_valid = 0 are allowed; there is no timeout.
  - After the last beat, go to WR_DONE.
- WR_DONE: write_done = 1 for one cycle, then IDLE.
- Backdoor:
  - bd_we_i writes are ignored while busy_o = 1.
  - A backdoor write takes effect at the clock edge and is visible on the following bus read.

Test Plan:
- Read burst: backdoor load words 0x10..0x17 = 0xA0..0xA7; read, addr=0x40, size=8, RD_LATENCY=2.
  - grant 1 cycle; read_valid 2 cycles later for 4 consecutive cycles.
  - Data 0x000000A1_000000A0 .. 0x000000A7_000000A6.
- Odd size read: size=9 from addr 0x40.
  - 5 beats; 5th beat = 0x00000000_000000A8.
- Write burst: write, addr=0x100, size=3; beats 0x2_1 then 0x4_3, with one idle cycle between.
  - Words 0x40, 0x41, 0x42 = 1, 2, 3 via backdoor; 4 discarded.
  - write_done pulses 1 cycle after the 2nd beat.
- Wrap: MEM_WORDS=1024, read addr=0xFFC, size=4.
  - Beats {w0,w1023} then {w2,w1}.
- Simultaneous read and write request in IDLE:
  - Only the read is granted; no memory change.
  - Read held high through the burst produces no second grant until IDLE.
- Reset mid-read after beat 2 of 4:
  - All outputs 0 next cycle; busy_o = 0.
  - A new read then completes normally with intact memory contents.
